data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32; data word width in bits.
REQ-002 Parameter DEPTH, default 64; number of words of storage, power of two.
REQ-003 Parameter WAIT_CYCLES, default 2; wait states between request acceptance and response, range 0-15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  DATA_WIDTH  write data.
REQ-011 rsp_valid  output  1  one-cycle response strobe.
REQ-012 rsp_rdata  output  DATA_WIDTH  read data, qualified by rsp_valid.
REQ-013 rsp_err  output  1  request was misaligned or out of range, qualified by rsp_valid.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE and 0 in WAIT and RESP.
REQ-016 The handshake occurs in any cycle T with req_valid && req_ready; the block SHALL latch req_we, req_addr and req_wdata at the end of T.
REQ-017 req_valid with req_ready=0 SHALL be ignored; it is neither queued nor dropped-with-error.
REQ-018 After a handshake, the FSM SHALL go from IDLE to WAIT, loading a 4-bit down-counter with WAIT_CYCLES-1; when WAIT_CYCLES=0 it SHALL go directly from IDLE to RESP.
REQ-019 WAIT SHALL decrement the counter each cycle and move to RESP in the cycle after the counter reads 0.
REQ-020 The FSM SHALL spend exactly one cycle in RESP and then return to IDLE.
REQ-021 rsp_valid SHALL be 1 only in RESP, in cycle T+WAIT_CYCLES+1; req_ready SHALL return to 1 in cycle T+WAIT_CYCLES+2.
REQ-022 The word index SHALL be latched_addr[log2(DEPTH)+1:2].
REQ-023 A request SHALL be in error when latched_addr[1:0] != 0 or latched_addr >= 4*DEPTH.
REQ-024 Error case: rsp_err=1, rsp_rdata=0, and storage SHALL NOT be modified.
REQ-025 Valid write: the word SHALL be committed at the end of the RESP cycle, with rsp_err=0 and rsp_rdata=0.
REQ-026 Valid read: rsp_rdata SHALL hold the stored word during RESP, with rsp_err=0.
REQ-027 A read following a write to the same word SHALL return the new value.
REQ-028 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.

Reset
REQ-029 With rst=1 at a clock edge, the FSM SHALL enter IDLE, clear the counter and latched request, and drive rsp_valid=0, rsp_err=0, rsp_rdata=0; req_ready SHALL be 1 in the first cycle after reset.
REQ-030 Reset in WAIT or RESP SHALL abort the transaction: no write commit and no rsp_valid.
REQ-031 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-032 With macro DMEM_RESP_STATS_EN defined, the block SHALL add outputs rd_count[15:0], wr_count[15:0] and err_count[15:0].
REQ-033 Under DMEM_RESP_STATS_EN, each counter SHALL increment in the RESP cycle of a valid read, a valid write or an error response respectively, saturate at 16'hFFFF, and reset to 0.
REQ-034 Without DMEM_RESP_STATS_EN, these ports and their logic SHALL be absent and behaviour is otherwise identical.

Verification
REQ-035 Write then read, WAIT_CYCLES=2: write addr 0x08, data 0xDEADBEEF, handshake in cycle 10 -> rsp_valid in cycle 13, req_ready=1 in cycle 14; read addr 0x08 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-036 Error cases: write addr 0x06 -> rsp_err=1 and word 1 unchanged; read addr 0x100 with DEPTH=64 -> rsp_err=1, rsp_rdata=0.
REQ-037 Back-pressure: req_valid held high with new data during WAIT -> ignored; only the first request takes effect; next handshake no earlier than cycle T+WAIT_CYCLES+2.
REQ-038 Reset mid-transaction: rst in the WAIT cycle of a write of 0x12345678 to 0x00 -> no rsp_valid; read 0x00 returns the prior value.
REQ-039 Zero wait: WAIT_CYCLES=0, handshake in cycle 5 -> rsp_valid in cycle 6; back-to-back reads sustain one response every 2 cycles.
REQ-040 Statistics, with DMEM_RESP_STATS_EN: 3 valid reads, 2 valid writes, 1 error -> rd_count=3, wr_count=2, err_count=1; rst -> all counters 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Single-port word memory behind a valid/ready request port with a fixed wait-state response.
// Optional per-type response counters are built when DMEM_RESP_STATS_EN is defined.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
`ifdef DMEM_RESP_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count,
  output logic [15:0]           err_count
`endif
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  req_t                  req_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  hs, req_err, commit;
  logic [AW-1:0]         idx;

  assign hs      = req_valid && req_ready;
  assign idx     = req_q.addr[AW+1:2];
  assign req_err = (req_q.addr[1:0] != 2'b00) || ({1'b0, req_q.addr} >= ADDR_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      req_q <= '0;
    end else if (hs) begin
      req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata};
      cnt   <= CNT_INIT;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response is gated by rst so a reset landing in RESP neither strobes nor commits.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
        if (!rst) begin
          rsp_valid = 1'b1;
          rsp_err   = req_err;
          if (!req_err && !req_q.we) rsp_rdata = mem[idx];
          commit    = !req_err && req_q.we;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (commit) mem[idx] <= req_q.wdata;
  end

`ifdef DMEM_RESP_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (rsp_valid) begin
      if (rsp_err)       err_count <= sat_inc(err_count);
      else if (req_q.we) wr_count  <= sat_inc(wr_count);
      else               rd_count  <= sat_inc(rd_count);
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboarded random bench for data_mem_responder: driver queues accepted requests,
// a negedge monitor computes each response from a word-array model at its due cycle.
module tb_data_mem_responder;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int W     = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
`ifdef DMEM_RESP_STATS_EN
  logic [15:0]   rd_count, wr_count, err_count;
`endif

  data_mem_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_RESP_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          we;
    bit [31:0]   addr;
    bit [DW-1:0] wdata;
    int          t;
  } txn_t;

  txn_t        q[$];
  bit [DW-1:0] model [DEPTH];
  int          checks = 0, errors = 0;
  int          last_t = 0;
  bit          hs_active = 1'b0;
  int          n_rd = 0, n_wr = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: busy window and response cycle follow only from the handshake cycle and W.
  always @(negedge clk) begin
    bit          busy, err;
    txn_t        x;
    bit [DW-1:0] exp_rd;
    int          wi;
    if (!rst) begin
      busy = hs_active && (cyc >= last_t + 1) && (cyc <= last_t + W + 1);
      check("req_ready", 64'(req_ready), 64'(!busy));
      if (q.size() > 0 && q[0].t + W + 1 == cyc) begin
        x      = q.pop_front();
        err    = (x.addr[1:0] != 2'b00) || (x.addr >= 32'(4 * DEPTH));
        wi     = int'(x.addr >> 2);
        exp_rd = '0;
        if (!err && !x.we) exp_rd = model[wi];
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_err", 64'(rsp_err), 64'(err));
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        if (err) n_err++;
        else if (x.we) begin model[wi] = x.wdata; n_wr++; end
        else n_rd++;
      end else begin
        check("rsp_idle", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
      end
    end
  end

  task automatic do_req(input bit we, input bit [31:0] addr, input bit [DW-1:0] wd, input bit junk);
    int   n = 0;
    txn_t x;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    while (!req_ready) begin
      if (n++ > 50) begin
        checks++; errors++;
        $display("FAIL handshake_timeout cycle %0d: req_ready stuck 0, expected 1", cyc);
        req_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    x.we = we; x.addr = addr; x.wdata = wd; x.t = cyc;
    q.push_back(x);
    last_t = cyc; hs_active = 1'b1;
    @(posedge clk); #1;
    if (junk) begin
      // keep offering fresh writes while busy; none of them may be accepted
      for (int k = 0; k <= W; k++) begin
        req_we = 1'b1;
        req_addr = 32'(4 * $urandom_range(0, DEPTH - 1));
        req_wdata = $urandom;
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
    q.delete(); hs_active = 1'b0;
    n_rd = 0; n_wr = 0; n_err = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 30) begin @(posedge clk); #1; n++; end
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout cycle %0d: %0d responses outstanding, expected 0", cyc, q.size());
    end
    @(posedge clk); #1;
  endtask

  function automatic bit [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return $urandom;
      1:       return 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
      2:       return 32'(4 * DEPTH + 4 * $urandom_range(0, 15));
      default: return 32'(4 * $urandom_range(0, DEPTH - 1));
    endcase
  endfunction

`ifdef DMEM_RESP_STATS_EN
  task automatic check_stats();
    check("rd_count", 64'(rd_count), 64'(n_rd));
    check("wr_count", 64'(wr_count), 64'(n_wr));
    check("err_count", 64'(err_count), 64'(n_err));
  endtask
`endif

  initial begin
    @(posedge clk); #1;
    do_reset(3);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);

    for (int i = 0; i < DEPTH; i++) do_req(1'b1, 32'(4 * i), $urandom, 1'b0);
    drain();

    do_req(1'b1, 32'h08, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 32'h08, '0, 1'b0);
    do_req(1'b1, 32'h06, 32'hCAFEF00D, 1'b0);
    do_req(1'b0, 32'h04, '0, 1'b0);
    do_req(1'b0, 32'h100, '0, 1'b0);
    do_req(1'b1, 32'h100, 32'h5555AAAA, 1'b0);
    do_req(1'b1, 32'h0C, 32'hA5A5A5A5, 1'b1);
    do_req(1'b1, 32'h10, 32'h0F0F0F0F, 1'b1);
    do_req(1'b0, 32'h0C, '0, 1'b0);
    do_req(1'b0, 32'h10, '0, 1'b0);
    drain();
`ifdef DMEM_RESP_STATS_EN
    check_stats();
`endif

    do_req(1'b1, 32'h00, 32'h12345678, 1'b0);
    do_reset(1);
`ifdef DMEM_RESP_STATS_EN
    check_stats();
`endif
    check("rst_mid_ready", 64'(req_ready), 64'd1);
    do_req(1'b0, 32'h00, '0, 1'b0);
    drain();

    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      do_req(1'($urandom), rand_addr(), $urandom, 1'($urandom_range(0, 3) == 0));
    end
    drain();
`ifdef DMEM_RESP_STATS_EN
    check_stats();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
